// File: rtl/dff_univ_shift_reg.sv
// Universal WIDTH-bit register: hold, parallel load, shift, rotate, clear, invert.
// The outputs are Q, its complement, and the two serial-out taps used for chaining.
module dff_univ_shift_reg #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             sout_msb,
  output logic             sout_lsb
);

  localparam logic [2:0] MODE_HOLD   = 3'b000;
  localparam logic [2:0] MODE_LOAD   = 3'b001;
  localparam logic [2:0] MODE_SHL    = 3'b010;
  localparam logic [2:0] MODE_SHR    = 3'b011;
  localparam logic [2:0] MODE_ROTL   = 3'b100;
  localparam logic [2:0] MODE_ROTR   = 3'b101;
  localparam logic [2:0] MODE_CLEAR  = 3'b110;
  localparam logic [2:0] MODE_INVERT = 3'b111;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Per-bit next-state select; each bit sees only its two neighbours or the serial inputs.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic shl_in;
    logic rotl_in;
    logic shr_in;
    logic rotr_in;

    if (gi == 0) begin : g_lo
      assign shl_in  = sin_lsb;
      assign rotl_in = q_q[WIDTH-1];
    end else begin : g_lo
      assign shl_in  = q_q[gi-1];
      assign rotl_in = q_q[gi-1];
    end

    if (gi == WIDTH-1) begin : g_hi
      assign shr_in  = sin_msb;
      assign rotr_in = q_q[0];
    end else begin : g_hi
      assign shr_in  = q_q[gi+1];
      assign rotr_in = q_q[gi+1];
    end

    always_comb begin
      q_d[gi] = q_q[gi];
      if (en) begin
        case (mode)
          MODE_HOLD:   q_d[gi] = q_q[gi];
          MODE_LOAD:   q_d[gi] = D[gi];
          MODE_SHL:    q_d[gi] = shl_in;
          MODE_SHR:    q_d[gi] = shr_in;
          MODE_ROTL:   q_d[gi] = rotl_in;
          MODE_ROTR:   q_d[gi] = rotr_in;
          MODE_CLEAR:  q_d[gi] = 1'b0;
          MODE_INVERT: q_d[gi] = ~q_q[gi];
          default:     q_d[gi] = q_q[gi];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q        = q_q;
  assign Q_bar    = ~q_q;
  assign sout_msb = q_q[WIDTH-1];
  assign sout_lsb = q_q[0];

endmodule

// File: tb/tb_dff_univ_shift_reg.sv
// Directed self-checking bench for dff_univ_shift_reg at WIDTH=4, RESET_VAL=0.
module tb_dff_univ_shift_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [3:0] d;
  logic       sin_lsb;
  logic       sin_msb;
  logic [3:0] q;
  logic [3:0] q_bar;
  logic       sout_msb;
  logic       sout_lsb;

  int checks;
  int failures;

  dff_univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .D        (d),
    .sin_lsb  (sin_lsb),
    .sin_msb  (sin_msb),
    .Q        (q),
    .Q_bar    (q_bar),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic [2:0] m, input logic [3:0] dv,
                      input logic sl, input logic sm);
    @(negedge clk);
    en = e; mode = m; d = dv; sin_lsb = sl; sin_msb = sm;
    @(posedge clk);
    #1;
    $display("txn t=%0t rst=%b en=%b mode=%b D=%b sl=%b sm=%b -> Q=%b", $time, rst, e, m, dv, sl, sm, q);
  endtask

  task automatic test_reset();
    @(negedge clk);
    en = 1'b1; mode = 3'b001; d = 4'b1111; sin_lsb = 1'b0; sin_msb = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 4'b0000) begin failures++; $display("FAIL reset_async_q got=%b exp=%b", q, 4'b0000); end
    checks++;
    if (q_bar !== 4'b1111) begin failures++; $display("FAIL reset_async_qbar got=%b exp=%b", q_bar, 4'b1111); end
    checks++;
    if ({sout_msb, sout_lsb} !== 2'b00) begin failures++; $display("FAIL reset_taps got=%b exp=%b", {sout_msb, sout_lsb}, 2'b00); end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 3'b001, 4'b1111, 1'b0, 1'b0);
      checks++;
      if (q !== 4'b0000) begin failures++; $display("FAIL reset_hold_edge%0d got=%b exp=%b", i, q, 4'b0000); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load();
    step(1'b1, 3'b001, 4'b1011, 1'b0, 1'b0);
    checks++;
    if (q !== 4'b1011) begin failures++; $display("FAIL load_q got=%b exp=%b", q, 4'b1011); end
    checks++;
    if (q_bar !== 4'b0100) begin failures++; $display("FAIL load_qbar got=%b exp=%b", q_bar, 4'b0100); end
    checks++;
    if ({sout_msb, sout_lsb} !== 2'b11) begin failures++; $display("FAIL load_taps got=%b exp=%b", {sout_msb, sout_lsb}, 2'b11); end
    step(1'b1, 3'b001, 4'b0110, 1'b0, 1'b0);
    checks++;
    if ({q, sout_msb, sout_lsb} !== 6'b0110_00) begin failures++; $display("FAIL load2_q_taps got=%b exp=%b", {q, sout_msb, sout_lsb}, 6'b0110_00); end
    step(1'b1, 3'b001, 4'b1011, 1'b0, 1'b0);
  endtask

  task automatic test_shift();
    step(1'b1, 3'b010, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (q !== 4'b0110) begin failures++; $display("FAIL shl_sin0 got=%b exp=%b", q, 4'b0110); end
    step(1'b1, 3'b011, 4'b0000, 1'b0, 1'b1);
    checks++;
    if (q !== 4'b1011) begin failures++; $display("FAIL shr_sin1 got=%b exp=%b", q, 4'b1011); end
    step(1'b1, 3'b010, 4'b0000, 1'b1, 1'b0);
    checks++;
    if (q !== 4'b0111) begin failures++; $display("FAIL shl_sin1 got=%b exp=%b", q, 4'b0111); end
    step(1'b1, 3'b011, 4'b0000, 1'b1, 1'b0);
    checks++;
    if (q !== 4'b0011) begin failures++; $display("FAIL shr_sin0 got=%b exp=%b", q, 4'b0011); end
    step(1'b1, 3'b001, 4'b1011, 1'b0, 1'b0);
  endtask

  task automatic test_rotate();
    logic [3:0] exp_rot [4];
    exp_rot[0] = 4'b0111; exp_rot[1] = 4'b1110; exp_rot[2] = 4'b1101; exp_rot[3] = 4'b1011;
    step(1'b1, 3'b100, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (q !== 4'b0111) begin failures++; $display("FAIL rotl got=%b exp=%b", q, 4'b0111); end
    step(1'b1, 3'b101, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (q !== 4'b1011) begin failures++; $display("FAIL rotr got=%b exp=%b", q, 4'b1011); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'b100, 4'b0000, 1'b1, 1'b1);
      checks++;
      if (q !== exp_rot[i]) begin failures++; $display("FAIL rotl_x4_step%0d got=%b exp=%b", i, q, exp_rot[i]); end
    end
    step(1'b1, 3'b101, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (q !== 4'b1101) begin failures++; $display("FAIL rotr_wrap got=%b exp=%b", q, 4'b1101); end
    step(1'b1, 3'b001, 4'b1011, 1'b0, 1'b0);
  endtask

  task automatic test_hold_clear_invert();
    logic [2:0] hold_modes [4];
    hold_modes[0] = 3'b001; hold_modes[1] = 3'b110; hold_modes[2] = 3'b111; hold_modes[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, hold_modes[i], 4'b0000, 1'b0, 1'b0);
      checks++;
      if (q !== 4'b1011) begin failures++; $display("FAIL en0_hold_mode%b got=%b exp=%b", hold_modes[i], q, 4'b1011); end
    end
    step(1'b1, 3'b000, 4'b0000, 1'b1, 1'b1);
    checks++;
    if (q !== 4'b1011) begin failures++; $display("FAIL mode_hold got=%b exp=%b", q, 4'b1011); end
    step(1'b1, 3'b110, 4'b1111, 1'b1, 1'b1);
    checks++;
    if (q !== 4'b0000) begin failures++; $display("FAIL clear got=%b exp=%b", q, 4'b0000); end
    step(1'b1, 3'b111, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (q !== 4'b1111 || q_bar !== 4'b0000) begin failures++; $display("FAIL invert got=%b/%b exp=%b/%b", q, q_bar, 4'b1111, 4'b0000); end
    step(1'b1, 3'b111, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (q !== 4'b0000) begin failures++; $display("FAIL invert_back got=%b exp=%b", q, 4'b0000); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    en = 1'b1; mode = 3'b111; d = 4'b0101;
    #3 mode = 3'b001; d = 4'b1010;
    @(posedge clk);
    #1;
    $display("txn t=%0t late-change load -> Q=%b", $time, q);
    checks++;
    if (q !== 4'b1010) begin failures++; $display("FAIL edge_sample_load got=%b exp=%b", q, 4'b1010); end
    mode = 3'b111; d = 4'b0000;
    #3;
    checks++;
    if (q !== 4'b1010) begin failures++; $display("FAIL midcycle_no_effect got=%b exp=%b", q, 4'b1010); end
    step(1'b1, 3'b001, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 3'b001, 4'b1000, 1'b0, 1'b0);
    checks++;
    if (q !== 4'b1000) begin failures++; $display("FAIL b2b_load got=%b exp=%b", q, 4'b1000); end
  endtask

  task automatic test_reset_hold();
    @(negedge clk);
    en = 1'b1; mode = 3'b001; d = 4'b1100;
    rst = 1'b1;
    #1;
    checks++;
    if (q !== 4'b0000) begin failures++; $display("FAIL rst2_async got=%b exp=%b", q, 4'b0000); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b001, 4'b1100, 1'b0, 1'b0);
      checks++;
      if (q !== 4'b0000) begin failures++; $display("FAIL rst2_edge%0d got=%b exp=%b", i, q, 4'b0000); end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("txn t=%0t reset release load -> Q=%b", $time, q);
    checks++;
    if (q !== 4'b1100) begin failures++; $display("FAIL rst_release_load got=%b exp=%b", q, 4'b1100); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; en = 1'b0; mode = 3'b000; d = 4'b0000; sin_lsb = 1'b0; sin_msb = 1'b0;
    test_reset();
    test_load();
    test_shift();
    test_rotate();
    test_hold_clear_invert();
    test_back_to_back();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
